// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, state encoding and datapath select codes for the multicycle control unit
package ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB, S_MEM_ADDR,
    S_LW_READ, S_LW_WB, S_SW_WRITE, S_BEQ, S_JUMP, S_EXC_OVF, S_EXC_OPC, S_EXC_LOAD
  } state_t;
  localparam logic [2:0] ALU_PASSA  = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [3:0] MTR_ALUOUT = 4'b0000;
  localparam logic [3:0] MTR_MDR    = 4'b0001;
  localparam logic [2:0] PCS_ALU    = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_VEC    = 3'b011;
  localparam logic [2:0] IOD_PC     = 3'b000;
  localparam logic [2:0] IOD_ALUOUT = 3'b001;
  localparam logic [2:0] IOD_OPC    = 3'b010;
  localparam logic [2:0] IOD_OVF    = 3'b011;
  localparam logic [2:0] WR_RT      = 3'b000;
  localparam logic [2:0] WR_RD      = 3'b001;
  localparam logic [2:0] WR_SP      = 3'b010;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMM2  = 2'b11;
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R)
      return (fn == FN_ADD || fn == FN_SUB || fn == FN_AND) ? S_R_EXEC : S_EXC_OPC;
    return op == OP_ADDI ? S_ADDI_EXEC :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           op == OP_BEQ ? S_BEQ :
           op == OP_J ? S_JUMP : S_EXC_OPC;
  endfunction
endpackage

// File: rtl/ctrl_wait_cnt.sv
// ctrl_wait_cnt: per-state cycle counter flagging the first and the MEM_WAIT-th cycle of a state
module ctrl_wait_cnt #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic first,
  output logic last
);
  logic [2:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (!last) cnt <= cnt + 3'd1;
  assign first = cnt == 3'd0;
  assign last  = cnt == 3'(MEM_WAIT);
endmodule

// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multicycle MIPS-subset control FSM with memory wait states and precise exceptions
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT    = 1,
  parameter bit          EXC_EN      = 1'b1,
  parameter logic [3:0]  SP_INIT_SEL = 4'b1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Zr,
  output logic       PC_write,
  output logic       MEM_write,
  output logic       IR_write,
  output logic       AB_w,
  output logic       Regwrite,
  output logic       ALUOutCtrl,
  output logic       EPC_write,
  output logic       MDR_write,
  output logic [2:0] Alu_control,
  output logic [3:0] MEMtoReg,
  output logic [2:0] PCsource,
  output logic [2:0] IorD,
  output logic [2:0] M_writeReg,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [4:0] state_o
);
  state_t state, next;
  logic first, last;
  ctrl_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk(clk), .reset(reset), .clr(next != state), .first(first), .last(last)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_RESET;
    else state <= next;
  always_comb begin
    next = S_RESET;
    case (state)
      S_RESET:     next = S_FETCH;
      S_FETCH:     next = last ? S_DECODE : S_FETCH;
      S_DECODE:    next = decode_next(OPCODE, FUNCT);
      S_R_EXEC:    next = (EXC_EN && Overflow && FUNCT != FN_AND) ? S_EXC_OVF : S_R_WB;
      S_ADDI_EXEC: next = (EXC_EN && Overflow) ? S_EXC_OVF : S_ADDI_WB;
      S_MEM_ADDR:  next = OPCODE == OP_LW ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:   next = last ? S_LW_WB : S_LW_READ;
      S_EXC_OVF:   next = last ? S_EXC_LOAD : S_EXC_OVF;
      S_EXC_OPC:   next = last ? S_EXC_LOAD : S_EXC_OPC;
      S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE, S_BEQ, S_JUMP, S_EXC_LOAD: next = S_FETCH;
      default:     next = S_RESET;
    endcase
  end
  always_comb begin
    PC_write    = 1'b0;
    MEM_write   = 1'b0;
    IR_write    = 1'b0;
    AB_w        = 1'b0;
    Regwrite    = 1'b0;
    ALUOutCtrl  = 1'b0;
    EPC_write   = 1'b0;
    MDR_write   = 1'b0;
    Alu_control = ALU_PASSA;
    MEMtoReg    = MTR_ALUOUT;
    PCsource    = PCS_ALU;
    IorD        = IOD_PC;
    M_writeReg  = WR_RT;
    AluSrcA     = SRCA_PC;
    AluSrcB     = SRCB_B;
    case (state)
      S_RESET: begin
        Regwrite   = 1'b1;
        M_writeReg = WR_SP;
        MEMtoReg   = SP_INIT_SEL;
      end
      S_FETCH: begin
        AluSrcB     = SRCB_4;
        Alu_control = ALU_ADD;
        PC_write    = last;
        IR_write    = last;
      end
      S_DECODE: begin
        AB_w        = 1'b1;
        ALUOutCtrl  = 1'b1;
        AluSrcB     = SRCB_IMM2;
        Alu_control = ALU_ADD;
      end
      S_R_EXEC: begin
        AluSrcA     = SRCA_A;
        ALUOutCtrl  = 1'b1;
        Alu_control = FUNCT == FN_SUB ? ALU_SUB : FUNCT == FN_AND ? ALU_AND : ALU_ADD;
      end
      S_R_WB: begin
        Regwrite   = 1'b1;
        M_writeReg = WR_RD;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        AluSrcA     = SRCA_A;
        AluSrcB     = SRCB_IMM;
        Alu_control = ALU_ADD;
        ALUOutCtrl  = 1'b1;
      end
      S_ADDI_WB: Regwrite = 1'b1;
      S_LW_READ: begin
        IorD      = IOD_ALUOUT;
        MDR_write = last;
      end
      S_LW_WB: begin
        Regwrite = 1'b1;
        MEMtoReg = MTR_MDR;
      end
      S_SW_WRITE: begin
        IorD      = IOD_ALUOUT;
        MEM_write = 1'b1;
      end
      S_BEQ: begin
        AluSrcA     = SRCA_A;
        Alu_control = ALU_SUB;
        PCsource    = PCS_ALUOUT;
        PC_write    = Zr;
      end
      S_JUMP: begin
        PC_write = 1'b1;
        PCsource = PCS_JUMP;
      end
      // EPC captures PC-4 on entry; the handler vector byte lands in MDR on the last cycle
      S_EXC_OVF, S_EXC_OPC: begin
        IorD        = state == S_EXC_OVF ? IOD_OVF : IOD_OPC;
        EPC_write   = first;
        AluSrcB     = first ? SRCB_4 : SRCB_B;
        Alu_control = first ? ALU_SUB : ALU_PASSA;
        MDR_write   = last;
      end
      S_EXC_LOAD: begin
        PC_write = 1'b1;
        PCsource = PCS_VEC;
      end
      default: ;
    endcase
  end
  assign state_o = state;
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb_ctrl_unit_mc: scoreboard bench; a cycle model queues expected state/outputs, compared at negedge
module tb_ctrl_unit_mc;
  import ctrl_pkg::*;
  typedef struct packed {
    logic pcw, memw, irw, abw, regw, aluout, epcw, mdrw;
    logic [2:0] alu;
    logic [3:0] mtr;
    logic [2:0] pcsrc, iord, mwr;
    logic [1:0] srca, srcb;
  } ctl_t;
  typedef struct packed {
    logic [4:0] st;
    ctl_t c;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic ovf = 1'b0;
  logic zr = 1'b0;
  bit sel = 1'b0;
  int mw = 1;
  bit exc = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  rec_t q[$];
  ctl_t got [2];
  logic [4:0] st [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pcw, memw, irw, abw, regw, aluout, epcw, mdrw;
    logic [2:0] alu, pcsrc, iord, mwr;
    logic [3:0] mtr;
    logic [1:0] srca, srcb;
    logic [4:0] s;
    ctrl_unit_mc #(.MEM_WAIT(g == 0 ? 1 : 2), .EXC_EN(g == 0), .SP_INIT_SEL(4'b1000)) dut (
      .clk(clk), .reset(reset), .OPCODE(opcode), .FUNCT(funct), .Overflow(ovf), .Zr(zr),
      .PC_write(pcw), .MEM_write(memw), .IR_write(irw), .AB_w(abw), .Regwrite(regw),
      .ALUOutCtrl(aluout), .EPC_write(epcw), .MDR_write(mdrw), .Alu_control(alu),
      .MEMtoReg(mtr), .PCsource(pcsrc), .IorD(iord), .M_writeReg(mwr),
      .AluSrcA(srca), .AluSrcB(srcb), .state_o(s)
    );
    assign got[g] = {pcw, memw, irw, abw, regw, aluout, epcw, mdrw, alu, mtr, pcsrc, iord, mwr, srca, srcb};
    assign st[g] = s;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push(input state_t s, input ctl_t c);
    q.push_back({s, c});
  endtask
  task automatic push_rst();
    ctl_t c;
    c = '0;
    c.regw = 1'b1;
    c.mwr = 3'b010;
    c.mtr = 4'b1000;
    push(S_RESET, c);
  endtask
  task automatic gen_exc(input state_t s, input logic [2:0] iord);
    ctl_t c;
    for (int i = 0; i <= mw; i++) begin
      c = '0;
      c.iord = iord;
      if (i == 0) begin
        c.epcw = 1'b1;
        c.srcb = 2'b01;
        c.alu = 3'b010;
      end
      c.mdrw = (i == mw);
      push(s, c);
    end
    c = '0;
    c.pcw = 1'b1;
    c.pcsrc = 3'b011;
    push(S_EXC_LOAD, c);
  endtask
  task automatic gen(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    for (int i = 0; i <= mw; i++) begin
      c = '0;
      c.srcb = 2'b01;
      c.alu = 3'b001;
      c.pcw = (i == mw);
      c.irw = (i == mw);
      push(S_FETCH, c);
    end
    c = '0;
    c.abw = 1'b1;
    c.aluout = 1'b1;
    c.srcb = 2'b11;
    c.alu = 3'b001;
    push(S_DECODE, c);
    if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100)) begin
      c = '0;
      c.srca = 2'b01;
      c.aluout = 1'b1;
      c.alu = fn == 6'b100010 ? 3'b010 : fn == 6'b100100 ? 3'b011 : 3'b001;
      push(S_R_EXEC, c);
      if (exc && ovf && fn != 6'b100100) gen_exc(S_EXC_OVF, 3'b011);
      else begin
        c = '0;
        c.regw = 1'b1;
        c.mwr = 3'b001;
        push(S_R_WB, c);
      end
    end else if (op == 6'b001000 || op == 6'b100011 || op == 6'b101011) begin
      c = '0;
      c.srca = 2'b01;
      c.srcb = 2'b10;
      c.alu = 3'b001;
      c.aluout = 1'b1;
      push(op == 6'b001000 ? S_ADDI_EXEC : S_MEM_ADDR, c);
      if (op == 6'b001000) begin
        if (exc && ovf) gen_exc(S_EXC_OVF, 3'b011);
        else begin
          c = '0;
          c.regw = 1'b1;
          push(S_ADDI_WB, c);
        end
      end else if (op == 6'b100011) begin
        for (int i = 0; i <= mw; i++) begin
          c = '0;
          c.iord = 3'b001;
          c.mdrw = (i == mw);
          push(S_LW_READ, c);
        end
        c = '0;
        c.regw = 1'b1;
        c.mtr = 4'b0001;
        push(S_LW_WB, c);
      end else begin
        c = '0;
        c.iord = 3'b001;
        c.memw = 1'b1;
        push(S_SW_WRITE, c);
      end
    end else if (op == 6'b000100) begin
      c = '0;
      c.srca = 2'b01;
      c.alu = 3'b010;
      c.pcsrc = 3'b001;
      c.pcw = zr;
      push(S_BEQ, c);
    end else if (op == 6'b000010) begin
      c = '0;
      c.pcw = 1'b1;
      c.pcsrc = 3'b010;
      push(S_JUMP, c);
    end else gen_exc(S_EXC_OPC, 3'b010);
  endtask
  task automatic drain_n(input int n);
    rec_t r;
    repeat (n) if (q.size() > 0) begin
      r = q.pop_front();
      check($sformatf("c%0d state", cyc), 32'(st[sel]), 32'(r.st));
      check($sformatf("c%0d ctl", cyc), 32'(got[sel]), 32'(r.c));
      cyc++;
      @(negedge clk);
    end
  endtask
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic o, input logic z);
    opcode = op;
    funct = fn;
    ovf = o;
    zr = z;
    gen(op, fn);
    drain_n(q.size());
  endtask
  initial begin
    logic [5:0] tbl_op [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000100,
                                6'b000100, 6'b000010, 6'b101011, 6'b111110, 6'b000000};
    logic [5:0] tbl_fn [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000001};
    logic tbl_ovf [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic tbl_zr [10]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    reset = 1'b0;
    push_rst();
    drain_n(1);
    for (int i = 0; i < 10; i++) run(tbl_op[i], tbl_fn[i], tbl_ovf[i], tbl_zr[i]);
    // abort an LW in its second read cycle with an asynchronous reset
    opcode = 6'b100011;
    funct = '0;
    ovf = 1'b0;
    gen(6'b100011, 6'b000000);
    drain_n(5);
    q.delete();
    #2 reset = 1'b1;
    #1 check("async reset", 32'(st[sel]), 32'(S_RESET));
    @(negedge clk);
    reset = 1'b0;
    push_rst();
    drain_n(1);
    run(6'b100011, 6'b000000, 1'b0, 1'b0);
    // second instance: two wait states, overflow trapping disabled
    sel = 1'b1;
    mw = 2;
    exc = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push_rst();
    drain_n(1);
    run(6'b100011, 6'b000000, 1'b0, 1'b0);
    run(6'b001000, 6'b000000, 1'b1, 1'b0);
    run(6'b000000, 6'b100010, 1'b1, 1'b0);
    run(6'b111110, 6'b000000, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
